// File: rtl/perf_counters_pkg.sv
// Shared CSR addresses, mhpmevent layout and helpers for the machine-mode counter unit.
package perf_counters_pkg;

  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_MHPMCOUNTER3  = 12'hB03;
  localparam logic [11:0] CSR_MHPMCOUNTER3H = 12'hB83;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MHPMEVENT3    = 12'h323;
  localparam logic [11:0] CSR_CYCLE         = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
  localparam logic [11:0] CSR_INSTRET       = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH      = 12'hC82;
  localparam logic [11:0] CSR_HPMCOUNTER3   = 12'hC03;
  localparam logic [11:0] CSR_HPMCOUNTER3H  = 12'hC83;

  localparam logic [7:0] HPM_SEL_NONE = 8'd0;

  typedef struct packed {
    logic        of;
    logic [22:0] reserved;
    logic [7:0]  sel;
  } mhpmevent_t;

  // Writable mcountinhibit bits: CY, IR and one per implemented HPM counter (TM stays 0).
  function automatic logic [31:0] inhibit_mask(int unsigned num_hpm);
    logic [31:0] m;
    m = 32'h0000_0005;
    for (int unsigned i = 0; i < num_hpm; i++) begin
      m[3+i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/hpm_counter.sv
// One programmable performance counter with its event selector and sticky overflow flag.
module hpm_counter
  import perf_counters_pkg::*;
#(
  parameter int unsigned HPM_WIDTH  = 40,
  parameter int unsigned NUM_EVENTS = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_EVENTS-1:0] events_i,
  input  logic                  inhibit_i,
  input  logic                  cnt_lo_we_i,
  input  logic                  cnt_hi_we_i,
  input  logic                  evt_we_i,
  input  logic [31:0]           wdata_i,
  output logic [63:0]           count_o,
  output logic [31:0]           event_o,
  output logic                  of_o
);

  logic [HPM_WIDTH-1:0] cnt_q, cnt_d;
  logic [HPM_WIDTH:0]   cnt_inc;
  logic [7:0]           sel_q, sel_d;
  logic                 of_q, of_d;
  logic                 event_hit;
  logic                 wrap;
  mhpmevent_t           evt;

  // Selectors outside 1..NUM_EVENTS match no input, so the counter stays idle.
  always_comb begin
    event_hit = 1'b0;
    if (sel_q != HPM_SEL_NONE) begin
      for (int unsigned i = 0; i < NUM_EVENTS; i++) begin
        event_hit = event_hit | (events_i[i] & (sel_q == 8'(i + 1)));
      end
    end
  end

  assign cnt_inc = {1'b0, cnt_q} + (HPM_WIDTH + 1)'(1);

  always_comb begin
    cnt_d = cnt_q;
    sel_d = sel_q;
    of_d  = of_q;
    wrap  = 1'b0;
    // A CSR write to either half drops this cycle's increment and any overflow from it.
    if (cnt_lo_we_i || cnt_hi_we_i) begin
      for (int b = 0; b < int'(HPM_WIDTH); b++) begin
        if (b < 32 ? cnt_lo_we_i : cnt_hi_we_i) begin
          cnt_d[b] = wdata_i[b%32];
        end
      end
    end else if (event_hit && !inhibit_i) begin
      cnt_d = cnt_inc[HPM_WIDTH-1:0];
      wrap  = cnt_inc[HPM_WIDTH];
    end
    if (evt_we_i) begin
      sel_d = wdata_i[7:0];
      of_d  = wdata_i[31];
    end
    // A hardware overflow is never lost to a simultaneous software clear.
    if (wrap) begin
      of_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      sel_q <= HPM_SEL_NONE;
      of_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sel_q <= sel_d;
      of_q  <= of_d;
    end
  end

  always_comb begin
    evt     = '0;
    evt.of  = of_q;
    evt.sel = sel_q;
  end

  assign count_o = 64'(cnt_q);
  assign event_o = evt;
  assign of_o    = of_q;

endmodule

// File: rtl/perf_counters.sv
// Machine-mode counter unit: mcycle, minstret, HPM counters, mcountinhibit, overflow IRQ.
module perf_counters
  import perf_counters_pkg::*;
#(
  parameter int unsigned NUM_HPM    = 4,
  parameter int unsigned HPM_WIDTH  = 40,
  parameter int unsigned NUM_EVENTS = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  csr_re_i,
  input  logic [11:0]           csr_raddr_i,
  output logic [31:0]           csr_rdata_o,
  output logic                  csr_hit_o,
  input  logic                  csr_we_i,
  input  logic [11:0]           csr_waddr_i,
  input  logic [31:0]           csr_wdata_i,
  input  logic                  instr_ret_i,
  input  logic [NUM_EVENTS-1:0] events_i,
  output logic                  irq_lcof_o,
  output logic [NUM_HPM-1:0]    overflow_o
);

  localparam logic [31:0] INHIBIT_MASK = inhibit_mask(NUM_HPM);

  logic [63:0]        mcycle_q, mcycle_d;
  logic [63:0]        minstret_q, minstret_d;
  logic [31:0]        inhibit_q, inhibit_d;
  logic               irq_q;
  logic [63:0]        hpm_cnt [NUM_HPM];
  logic [31:0]        hpm_evt [NUM_HPM];
  logic [NUM_HPM-1:0] hpm_of;
  logic               rd_hit;
  logic [31:0]        rd_data;

  always_comb begin
    mcycle_d   = mcycle_q;
    minstret_d = minstret_q;
    inhibit_d  = inhibit_q;
    if (csr_we_i && csr_waddr_i == CSR_MCYCLE) begin
      mcycle_d[31:0] = csr_wdata_i;
    end else if (csr_we_i && csr_waddr_i == CSR_MCYCLEH) begin
      mcycle_d[63:32] = csr_wdata_i;
    end else if (!inhibit_q[0]) begin
      mcycle_d = mcycle_q + 64'd1;
    end
    if (csr_we_i && csr_waddr_i == CSR_MINSTRET) begin
      minstret_d[31:0] = csr_wdata_i;
    end else if (csr_we_i && csr_waddr_i == CSR_MINSTRETH) begin
      minstret_d[63:32] = csr_wdata_i;
    end else if (instr_ret_i && !inhibit_q[2]) begin
      minstret_d = minstret_q + 64'd1;
    end
    if (csr_we_i && csr_waddr_i == CSR_MCOUNTINHIBIT) begin
      inhibit_d = csr_wdata_i & INHIBIT_MASK;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
      inhibit_q  <= '0;
      irq_q      <= 1'b0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
      inhibit_q  <= inhibit_d;
      irq_q      <= |hpm_of;
    end
  end

  for (genvar k = 0; k < NUM_HPM; k++) begin : g_hpm
    hpm_counter #(
      .HPM_WIDTH  (HPM_WIDTH),
      .NUM_EVENTS (NUM_EVENTS)
    ) u_hpm_counter (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .events_i    (events_i),
      .inhibit_i   (inhibit_q[3+k]),
      .cnt_lo_we_i (csr_we_i && csr_waddr_i == CSR_MHPMCOUNTER3 + 12'(k)),
      .cnt_hi_we_i (csr_we_i && csr_waddr_i == CSR_MHPMCOUNTER3H + 12'(k)),
      .evt_we_i    (csr_we_i && csr_waddr_i == CSR_MHPMEVENT3 + 12'(k)),
      .wdata_i     (csr_wdata_i),
      .count_o     (hpm_cnt[k]),
      .event_o     (hpm_evt[k]),
      .of_o        (hpm_of[k])
    );
  end

  // Reads see pre-edge state, so a same-cycle write is not visible yet.
  always_comb begin
    rd_hit  = 1'b1;
    rd_data = '0;
    unique case (csr_raddr_i)
      CSR_MCYCLE, CSR_CYCLE:          rd_data = mcycle_q[31:0];
      CSR_MCYCLEH, CSR_CYCLEH:        rd_data = mcycle_q[63:32];
      CSR_MINSTRET, CSR_INSTRET:      rd_data = minstret_q[31:0];
      CSR_MINSTRETH, CSR_INSTRETH:    rd_data = minstret_q[63:32];
      CSR_MCOUNTINHIBIT:              rd_data = inhibit_q;
      default:                        rd_hit  = 1'b0;
    endcase
    for (int unsigned k = 0; k < NUM_HPM; k++) begin
      if (csr_raddr_i == CSR_MHPMCOUNTER3 + 12'(k) || csr_raddr_i == CSR_HPMCOUNTER3 + 12'(k)) begin
        rd_hit  = 1'b1;
        rd_data = hpm_cnt[k][31:0];
      end
      if (csr_raddr_i == CSR_MHPMCOUNTER3H + 12'(k)
          || csr_raddr_i == CSR_HPMCOUNTER3H + 12'(k)) begin
        rd_hit  = 1'b1;
        rd_data = hpm_cnt[k][63:32];
      end
      if (csr_raddr_i == CSR_MHPMEVENT3 + 12'(k)) begin
        rd_hit  = 1'b1;
        rd_data = hpm_evt[k];
      end
    end
  end

  assign csr_hit_o   = csr_re_i & rd_hit;
  assign csr_rdata_o = (csr_re_i && rd_hit) ? rd_data : 32'd0;
  assign irq_lcof_o  = irq_q;
  assign overflow_o  = hpm_of;

endmodule

// File: tb/tb_perf_counters.sv
// Directed and randomized checks of perf_counters against an arithmetic reference model.
module tb_perf_counters;

  localparam int unsigned NUM_HPM    = 4;
  localparam int unsigned HPM_WIDTH  = 40;
  localparam int unsigned NUM_EVENTS = 8;
  localparam logic [63:0] HPM_MASK   = (64'd1 << HPM_WIDTH) - 64'd1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  csr_re;
  logic [11:0]           raddr;
  logic [31:0]           rdata;
  logic                  hit;
  logic                  we;
  logic [11:0]           waddr;
  logic [31:0]           wdata;
  logic                  ret;
  logic [NUM_EVENTS-1:0] events;
  logic                  irq;
  logic [NUM_HPM-1:0]    ovf;

  int errors = 0;
  int checks = 0;

  perf_counters #(
    .NUM_HPM    (NUM_HPM),
    .HPM_WIDTH  (HPM_WIDTH),
    .NUM_EVENTS (NUM_EVENTS)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .csr_re_i    (csr_re),
    .csr_raddr_i (raddr),
    .csr_rdata_o (rdata),
    .csr_hit_o   (hit),
    .csr_we_i    (we),
    .csr_waddr_i (waddr),
    .csr_wdata_i (wdata),
    .instr_ret_i (ret),
    .events_i    (events),
    .irq_lcof_o  (irq),
    .overflow_o  (ovf)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [63:0] m_cycle, m_instret;
  logic [63:0] m_hpm [NUM_HPM];
  logic [7:0]  m_sel [NUM_HPM];
  logic        m_of  [NUM_HPM];
  logic [31:0] m_inh;
  logic        m_irq;
  bit          m_valid = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] set_lo(input logic [63:0] v, input logic [31:0] d);
    return (v & 64'hFFFF_FFFF_0000_0000) | {32'd0, d};
  endfunction

  function automatic logic [63:0] set_hi(input logic [63:0] v, input logic [31:0] d);
    return (v & 64'h0000_0000_FFFF_FFFF) | ({32'd0, d} << 32);
  endfunction

  task automatic model_step();
    logic        irq_next;
    logic [31:0] inh;
    int          s;
    if (rst) begin
      m_cycle = '0; m_instret = '0; m_inh = '0; m_irq = 1'b0; m_valid = 1'b1;
      for (int k = 0; k < int'(NUM_HPM); k++) begin
        m_hpm[k] = '0; m_sel[k] = '0; m_of[k] = 1'b0;
      end
      return;
    end
    if (!m_valid) return;
    irq_next = 1'b0;
    for (int k = 0; k < int'(NUM_HPM); k++) irq_next |= m_of[k];
    inh = m_inh;
    if (we && waddr == 12'hB00)      m_cycle = set_lo(m_cycle, wdata);
    else if (we && waddr == 12'hB80) m_cycle = set_hi(m_cycle, wdata);
    else if (!inh[0])                m_cycle = m_cycle + 64'd1;
    if (we && waddr == 12'hB02)      m_instret = set_lo(m_instret, wdata);
    else if (we && waddr == 12'hB82) m_instret = set_hi(m_instret, wdata);
    else if (ret && !inh[2])         m_instret = m_instret + 64'd1;
    for (int k = 0; k < int'(NUM_HPM); k++) begin
      logic wrapped;
      logic fire;
      wrapped = 1'b0;
      s = int'(m_sel[k]);
      fire = (s >= 1 && s <= int'(NUM_EVENTS)) ? events[s-1] : 1'b0;
      if (we && waddr == 12'hB03 + 12'(k))      m_hpm[k] = set_lo(m_hpm[k], wdata) & HPM_MASK;
      else if (we && waddr == 12'hB83 + 12'(k)) m_hpm[k] = set_hi(m_hpm[k], wdata) & HPM_MASK;
      else if (fire && !inh[3+k]) begin
        m_hpm[k] = (m_hpm[k] + 64'd1) & HPM_MASK;
        wrapped  = (m_hpm[k] == 64'd0);
      end
      if (we && waddr == 12'h323 + 12'(k)) begin
        m_sel[k] = wdata[7:0];
        m_of[k]  = wdata[31];
      end
      if (wrapped) m_of[k] = 1'b1;
    end
    if (we && waddr == 12'h320) m_inh = wdata & (32'h5 | (((32'd1 << NUM_HPM) - 32'd1) << 3));
    m_irq = irq_next;
  endtask

  task automatic model_read(input logic [11:0] a, output logic h, output logic [31:0] d);
    h = 1'b0;
    d = '0;
    if (!csr_re) return;
    if (a == 12'hB00 || a == 12'hC00) begin h = 1'b1; d = m_cycle[31:0]; end
    if (a == 12'hB80 || a == 12'hC80) begin h = 1'b1; d = m_cycle[63:32]; end
    if (a == 12'hB02 || a == 12'hC02) begin h = 1'b1; d = m_instret[31:0]; end
    if (a == 12'hB82 || a == 12'hC82) begin h = 1'b1; d = m_instret[63:32]; end
    if (a == 12'h320) begin h = 1'b1; d = m_inh; end
    for (int k = 0; k < int'(NUM_HPM); k++) begin
      if (a == 12'hB03 + 12'(k) || a == 12'hC03 + 12'(k)) begin h = 1'b1; d = m_hpm[k][31:0]; end
      if (a == 12'hB83 + 12'(k) || a == 12'hC83 + 12'(k)) begin h = 1'b1; d = m_hpm[k][63:32]; end
      if (a == 12'h323 + 12'(k)) begin h = 1'b1; d = {m_of[k], 23'd0, m_sel[k]}; end
    end
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    logic        eh;
    logic [31:0] ed;
    logic        any_of;
    if (m_valid) begin
      model_read(raddr, eh, ed);
      chk("model hit", hit, eh);
      chk("model rdata", rdata, ed);
      chk("model irq", irq, m_irq);
      any_of = 1'b0;
      for (int k = 0; k < int'(NUM_HPM); k++) begin
        chk("model overflow", ovf[k], m_of[k]);
        any_of |= m_of[k];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp, input logic exp_hit,
                    input string name);
    raddr  = a;
    csr_re = 1'b1;
    @(negedge clk);
    chk({name, " hit"}, hit, exp_hit);
    chk(name, rdata, exp);
    tick();
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  logic [11:0] addr_list [24];

  initial begin
    addr_list = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hB03, 12'hB04, 12'hB05, 12'hB06,
                  12'hB83, 12'hB84, 12'hB85, 12'hB86, 12'h320, 12'h323, 12'h324, 12'h325,
                  12'h326, 12'hC00, 12'hC03, 12'hC86, 12'hB07, 12'h327, 12'hB1F, 12'hC07};
    rst = 1'b1; csr_re = 1'b0; raddr = '0; we = 1'b0; waddr = '0; wdata = '0;
    ret = 1'b0; events = '0;
    tick();
    tick();
    rst = 1'b0;

    // Idle counting and reset values
    for (int i = 0; i < 10; i++) begin
      ret = (i < 4);
      tick();
    end
    ret = 1'b0;
    rd(12'hB00, 32'd10, 1'b1, "mcycle after 10");
    rd(12'hB02, 32'd4, 1'b1, "minstret after 4");
    rd(12'hB80, 32'd0, 1'b1, "mcycleh reset");
    rd(12'hB03, 32'd0, 1'b1, "mhpmcounter3 reset");
    rd(12'h323, 32'd0, 1'b1, "mhpmevent3 reset");
    rd(12'h320, 32'd0, 1'b1, "mcountinhibit reset");
    rd(12'hB1F, 32'd0, 1'b0, "B1F miss");

    // Event selection
    wr(12'h323, 32'd2);
    for (int i = 0; i < 10; i++) begin
      events = (i < 7) ? 8'h02 : 8'h01;
      tick();
    end
    events = '0;
    rd(12'hB03, 32'd7, 1'b1, "mhpmcounter3 events");
    rd(12'hB04, 32'd0, 1'b1, "mhpmcounter4 unselected");

    // Overflow at 40 bits
    wr(12'hB03, 32'hFFFF_FFFF);
    wr(12'hB83, 32'h0000_00FF);
    events = 8'h02;
    tick();
    events = '0;
    raddr = 12'hB03;
    @(negedge clk);
    chk("wrapped counter", rdata, 32'd0);
    chk("overflow_o[0] set", ovf[0], 1'b1);
    chk("irq not yet", irq, 1'b0);
    tick();
    @(negedge clk);
    chk("irq one cycle later", irq, 1'b1);
    tick();
    rd(12'h323, 32'h8000_0002, 1'b1, "mhpmevent3 OF");
    wr(12'h323, 32'd2);
    @(negedge clk);
    chk("OF cleared", ovf[0], 1'b0);
    chk("irq still high", irq, 1'b1);
    tick();
    @(negedge clk);
    chk("irq cleared", irq, 1'b0);
    tick();

    // Write wins over increment
    wr(12'hB00, 32'h100);
    rd(12'hB00, 32'h100, 1'b1, "mcycle written");
    rd(12'hB00, 32'h101, 1'b1, "mcycle resumes");
    rd(12'hB80, 32'h0, 1'b1, "mcycleh unchanged");

    // Inhibit
    wr(12'h320, 32'h5);
    ret = 1'b1;
    repeat (20) tick();
    ret = 1'b0;
    rd(12'hB00, 32'h104, 1'b1, "mcycle frozen");
    rd(12'hB02, 32'd4, 1'b1, "minstret frozen");
    ret = 1'b1;
    wr(12'h320, 32'h0);
    tick();
    ret = 1'b0;
    rd(12'hB00, 32'h105, 1'b1, "mcycle resumed");
    rd(12'hB02, 32'd5, 1'b1, "minstret resumed");

    // Misses and shadow writes
    rd(12'hC07, 32'd0, 1'b0, "C07 miss");
    wr(12'hC00, 32'hDEAD);
    rd(12'hB00, 32'h109, 1'b1, "mcycle ignores C00 write");

    // Randomized traffic checked by the model every cycle
    for (int i = 0; i < 4000; i++) begin
      rst    = ($urandom_range(0, 499) == 0);
      csr_re = ($urandom_range(0, 3) != 0);
      raddr  = addr_list[$urandom_range(0, 23)];
      ret    = 1'($urandom);
      events = NUM_EVENTS'($urandom);
      we     = ($urandom_range(0, 5) == 0);
      waddr  = addr_list[$urandom_range(0, 23)];
      if (waddr == 12'h320) begin
        wdata = ($urandom_range(0, 3) == 0) ? $urandom : 32'd0;
      end else if (waddr >= 12'h323 && waddr <= 12'h327) begin
        wdata = {1'($urandom), 23'($urandom), 8'($urandom_range(0, 10))};
      end else begin
        case ($urandom_range(0, 3))
          0:       wdata = 32'hFFFF_FFFF;
          1:       wdata = 32'hFFFF_FFFE;
          2:       wdata = 32'h0000_00FF;
          default: wdata = $urandom;
        endcase
      end
      tick();
    end
    rst = 1'b0; we = 1'b0; events = '0; ret = 1'b0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/perf_counters.md
Name: perf_counters

Overview:
- Parametrised machine-mode counter unit: mcycle, minstret, NUM_HPM programmable hardware performance counters (mhpmcounter3+), their event selectors (mhpmevent3+), and mcountinhibit.
- Sits beside the CS register file, inside the privileged unit, on the same M-stage CSR read/write port.
- Adds Sscofpmf-style sticky overflow flags and an overflow interrupt request.

Parameters:
- NUM_HPM, 4: number of programmable counters, 0..29; they map to mhpmcounter3..(3+NUM_HPM-1).
- HPM_WIDTH, 40: implemented width of each programmable counter, 1..64; unimplemented upper bits read 0 and ignore writes.
- NUM_EVENTS, 8: width of the event input vector, 1..255.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- csr_re_i  in  1  read enable
- csr_raddr_i  in  12  read address
- csr_rdata_o  out  32  read data (combinational)
- csr_hit_o  out  1  csr_raddr_i decodes to a register in this block
- csr_we_i  in  1  write enable (already stall-gated by the caller)
- csr_waddr_i  in  12  write address
- csr_wdata_i  in  32  write data
- instr_ret_i  in  1  one instruction retired this cycle
- events_i  in  NUM_EVENTS  per-cycle event pulses
- irq_lcof_o  out  1  local counter-overflow interrupt request
- overflow_o  out  NUM_HPM  sticky overflow flags

Behaviour:
- Reset: all counters = 0, mhpmevent = 0, mcountinhibit = 0, overflow_o = 0, irq_lcof_o = 0.
- Address map (machine mode):
  - mcycle B00/B80, minstret B02/B82
  - mhpmcounterN B03+k / B83+k
  - mcountinhibit 320, mhpmeventN 323+k
  - user read-only shadows C00/C80, C02/C82, C03+k/C83+k; writes to these are ignored.
- Read path:
  - csr_rdata_o is combinational from current state.
  - csr_hit_o = csr_re_i & address-in-map; on a miss, csr_rdata_o = 0.
  - Addresses for k >= NUM_HPM miss.
- mcycle/minstret are 64-bit. Each increments by 1 per cycle, or per instr_ret_i, unless inhibited (mcountinhibit bit 0 / bit 2).
- mhpmevent fields:
  - [7:0] = event select sel.
  - [31] = OF, sticky overflow flag, mirrored on overflow_o[k].
  - Other bits read 0.
  - sel in 1..NUM_EVENTS: counter k increments when events_i[sel-1] = 1 and mcountinhibit[3+k] = 0.
  - sel = 0 or sel > NUM_EVENTS: counter never increments.
- Width: counter k wraps modulo 2^HPM_WIDTH. The increment that produces the wrap to 0 sets OF[k] in the same clock edge.
- OF[k] is cleared only by a CSR write of mhpmevent with bit31 = 0; software may also set it by writing 1.
- irq_lcof_o is registered: asserts the cycle after any OF becomes 1, deasserts the cycle after all are 0.
- Write/increment collision: a CSR write to any half of a counter wins. That cycle's increment is dropped, and no overflow is generated from it.
- Half writes: a low-half write replaces bits [31:0], a high-half write replaces [63:32]; the other half is unchanged and no carry propagates.
- mcountinhibit writes take effect for increments starting the cycle after the write. Bit 1 (time) is hard-wired 0. Bits for unimplemented counters are hard-wired 0.
- Write and read of the same register in one cycle: the read returns the old value (registered write).
- Reset asserted mid-count: all state returns to reset values at that edge. No increment is applied that edge.

Decomposition:
- csr_pkg gains:
  - address constants: CSR_MCYCLE(H), CSR_MINSTRET(H), CSR_MHPMCOUNTER3(H), CSR_MHPMEVENT3, CSR_MCOUNTINHIBIT, user shadow bases
  - mhpmevent_t packed struct: of, reserved, sel[7:0]
  - HPM_SEL_NONE = 8'd0
- One sub-module, hpm_counter, instantiated NUM_HPM times via generate. It holds one counter, its event select, its OF flag, and the write-wins/overflow logic.
- mcycle/minstret stay inline in perf_counters.

Test Plan:
- Reset, then 10 idle cycles with instr_ret_i = 1 on 4 of them -> mcycle reads 10, minstret reads 4, all other registers read 0, csr_hit_o = 1 for B00, 0 for B1F.
- Write mhpmevent3 = 2, pulse events_i[1] 7 times and events_i[0] 3 times -> mhpmcounter3 = 7, mhpmcounter4 = 0.
- HPM_WIDTH = 40: write mhpmcounter3 = 0xFFFFFFFF and mhpmcounter3h = 0xFF, then one event -> counter reads 0, mhpmevent3[31] = 1, overflow_o[0] = 1, irq_lcof_o = 1 one cycle later; write mhpmevent3 = 2 -> irq_lcof_o = 0 one cycle after.
- CSR write of mcycle = 0x100 in the same cycle as an increment -> next read is 0x100, next cycle 0x101; mcycleh is unchanged.
- Set mcountinhibit = 0x5, run 20 cycles with retirement -> mcycle and minstret frozen; clear it -> both resume on the following cycle.
- Read address C03+NUM_HPM and a write to C00 -> csr_hit_o = 0 / rdata 0, and mcycle is unaffected by the write.
